// File: rtl/demux_scheduler.sv
// Round-robin scheduler that steers one valid/ready input stream onto four demuxed channels.
// Optional HOLD timeout with a one-cycle drop pulse is enabled by defining DEMUX_TIMEOUT_EN.
module demux_scheduler #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic [3:0]       en_mask,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic             s0,
  output logic             s1,
  output logic             busy
`ifdef DEMUX_TIMEOUT_EN
  ,
  output logic             drop
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("demux_scheduler: TIMEOUT must lie in 2..255");
  end

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [1:0]       sel_pick;
  logic             found;
  logic [1:0]       probe;
`ifdef DEMUX_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic             drop_q, drop_d;
`endif

  // Round-robin search starting at ptr; the 2-bit index wraps mod 4 by itself.
  always_comb begin
    sel_pick = ptr_q;
    found    = 1'b0;
    probe    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      probe = ptr_q + 2'(i);
      if (!found && en_mask[probe]) begin
        sel_pick = probe;
        found    = 1'b1;
      end
    end
  end

  assign d_ready = (state_q == IDLE) && (en_mask != 4'b0000);
  assign busy    = (state_q == HOLD);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    buf_d   = buf_q;
`ifdef DEMUX_TIMEOUT_EN
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (d_valid && d_ready) begin
          buf_d   = D;
          sel_d   = sel_pick;
          state_d = HOLD;
`ifdef DEMUX_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      HOLD: begin
        if (y_ready[sel_q]) begin
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
        end
`ifdef DEMUX_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
          drop_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      buf_q   <= '0;
`ifdef DEMUX_TIMEOUT_EN
      cnt_q   <= 8'd0;
      drop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      buf_q   <= buf_d;
`ifdef DEMUX_TIMEOUT_EN
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
`endif
    end
  end

  // Demux semantics: only the selected channel carries the word, all others read zero.
  assign y_valid = busy ? (4'b0001 << sel_q) : 4'b0000;
  assign y0      = (busy && sel_q == 2'd0) ? buf_q : '0;
  assign y1      = (busy && sel_q == 2'd1) ? buf_q : '0;
  assign y2      = (busy && sel_q == 2'd2) ? buf_q : '0;
  assign y3      = (busy && sel_q == 2'd3) ? buf_q : '0;
  assign s0      = sel_q[0];
  assign s1      = sel_q[1];
`ifdef DEMUX_TIMEOUT_EN
  assign drop    = drop_q;
`endif

endmodule

// File: tb/tb_demux_scheduler.sv
// Scoreboard bench for demux_scheduler: expected {channel,data} pairs are queued on acceptance
// and popped when the selected channel completes its handshake.
module tb_demux_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] D;
  logic       d_valid;
  logic       d_ready;
  logic [3:0] en_mask;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] y_valid;
  logic [3:0] y_ready;
  logic       s0, s1, busy;
`ifdef DEMUX_TIMEOUT_EN
  logic       drop;
`endif

  always #5 clk = ~clk;

  demux_scheduler #(.WIDTH(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .D(D), .d_valid(d_valid), .d_ready(d_ready),
    .en_mask(en_mask), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .y_valid(y_valid), .y_ready(y_ready), .s0(s0), .s1(s1), .busy(busy)
`ifdef DEMUX_TIMEOUT_EN
    , .drop(drop)
`endif
  );

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  int   last_acc = 0;
  bit   mon_en   = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Channel monitor: demux exclusivity every cycle, scoreboard pop on handshake.
  logic [7:0] mon_y[4];
  int         mon_idx;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_y   = '{y0, y1, y2, y3};
      mon_idx = int'({s1, s0});
      if (y_valid != 4'b0000) begin
        check("yv_onehot", y_valid, 4'b0001 << mon_idx);
        check("busy_hold", busy, 1);
        check("dready_hold", d_ready, 0);
        for (int k = 0; k < 4; k++)
          if (k != mon_idx) check("y_unsel_zero", mon_y[k], 0);
        if (y_ready[mon_idx]) begin
          if (sb.size() == 0) check("sb_underflow", 1, 0);
          else begin
            mon_e = sb.pop_front();
            check("chan", mon_idx, mon_e.ch);
            check("data", mon_y[mon_idx], mon_e.data);
          end
        end
      end else begin
        check("idle_y_zero", y0 | y1 | y2 | y3, 0);
      end
    end
  end

  // Drives a word and waits (bounded) for acceptance; returns just after the accepting edge.
  task automatic send(input logic [7:0] data, input logic [1:0] ch);
    int waited = 0;
    D       = data;
    d_valid = 1'b1;
    @(negedge clk);
    while (!d_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!d_ready) begin
      check("accept_timeout", 0, 1);
      d_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(exp_t'{ch: ch, data: data});
    #1;
    last_acc = cycle;
    d_valid  = 1'b0;
    D        = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
  endtask

  logic [7:0] t1_data[5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
  logic [1:0] t1_ch[5]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] t2_data[3] = '{8'h11, 8'h22, 8'h33};
  logic [1:0] t2_ch[3]   = '{2'd1, 2'd3, 2'd1};

  initial begin
    int prev;
    rst = 1'b1; D = 8'h00; d_valid = 1'b0; en_mask = 4'b0000; y_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_yvalid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", {s1, s0}, 0);
    check("rst_y", y0 | y1 | y2 | y3, 0);
    check("rst_dready_mask0", d_ready, 0);
`ifdef DEMUX_TIMEOUT_EN
    check("rst_drop", drop, 0);
`endif
    mon_en = 1'b1;

    // Full round robin, one word every two cycles.
    @(posedge clk); #1 en_mask = 4'b1111; y_ready = 4'b1111;
    #1 check("dready_idle", d_ready, 1);
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      send(t1_data[i], t1_ch[i]);
      if (i > 0) check("spacing", last_acc - prev, 2);
      prev = last_acc;
      @(negedge clk);
      check("latency_yv", y_valid, 4'b0001 << t1_ch[i]);
    end

    // Sparse mask skips disabled channels.
    do_reset();
    en_mask = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      send(t2_data[i], t2_ch[i]);
      @(negedge clk);
      check("mask_yv", y_valid, 4'b0001 << t2_ch[i]);
    end

    // Back-pressure: word held until y_ready[0].
    @(posedge clk); #1 en_mask = 4'b0001; y_ready = 4'b0000;
    send(8'h5C, 2'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_y0", y0, 8'h5C);
      check("bp_yv", y_valid, 4'b0001);
      check("bp_dready", d_ready, 0);
      check("bp_busy", busy, 1);
    end
    @(posedge clk); #1 y_ready = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_yv", y_valid, 0);
    check("bp_release_dready", d_ready, 1);
    check("sel_hold_idle", {s1, s0}, 0);

    // Empty mask stalls, then a single enabled channel takes the word.
    @(posedge clk); #1 y_ready = 4'b1111; en_mask = 4'b0000; D = 8'h99; d_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mask0_dready", d_ready, 0);
      check("mask0_yv", y_valid, 0);
    end
    @(posedge clk); #1 en_mask = 4'b0100;
    send(8'h99, 2'd2);
    @(negedge clk);
    check("mask4_yv", y_valid, 4'b0100);

    // Reset mid-HOLD discards the word and restarts the pointer.
    @(posedge clk); #1 y_ready = 4'b0000; en_mask = 4'b0100;
    send(8'h77, 2'd2);
    @(negedge clk);
    check("pre_rst_y2", y2, 8'h77);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    check("midrst_yv", y_valid, 0);
    check("midrst_y", y0 | y1 | y2 | y3, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sel", {s1, s0}, 0);
`ifdef DEMUX_TIMEOUT_EN
    check("midrst_drop", drop, 0);
`endif
    en_mask = 4'b1111; y_ready = 4'b1111;
    send(8'h78, 2'd0);
    @(negedge clk);
    check("post_rst_yv", y_valid, 4'b0001);

`ifdef DEMUX_TIMEOUT_EN
    // Timeout after four HOLD cycles, then acceptance in the last cycle beats expiry.
    do_reset();
    en_mask = 4'b1111; y_ready = 4'b0000;
    send(8'hE0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_hold_yv", y_valid, 4'b0001);
      check("to_hold_drop", drop, 0);
    end
    @(negedge clk);
    check("to_drop_pulse", drop, 1);
    check("to_drop_yv", y_valid, 0);
    sb.delete();
    @(negedge clk);
    check("to_drop_once", drop, 0);
    @(posedge clk); #1;
    send(8'hE1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("to2_hold_yv", y_valid, 4'b0010);
      @(posedge clk); #1;
    end
    y_ready = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check("to2_no_drop", drop, 0);
    check("to2_yv", y_valid, 0);
    check("to2_sb_empty", sb.size(), 0);
`endif

    @(posedge clk); #1 y_ready = 4'b1111;
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/demux_scheduler.md
Name: demux_scheduler

Overview:
- Round-robin scheduler that shares a single input data stream across four output channels using a 1-to-4 demux datapath.
- Accepts one word at a time with a valid/ready handshake. Picks the next enabled channel, drives the demux selects (s1,s0), and holds the word until that channel accepts it.
- Sits in front of channel consumers that each have their own ready signal.

Parameters:
- WIDTH, 8, data word width in bits.
- TIMEOUT, 16, maximum HOLD cycles before a drop. Used only with DEMUX_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- D  input  WIDTH  input data word.
- d_valid  input  1  D is valid.
- d_ready  output  1  scheduler can accept D.
- en_mask  input  4  per-channel enable; bit k enables channel k.
- y0, y1, y2, y3  output  WIDTH each  channel data outputs.
- y_valid  output  4  per-channel valid.
- y_ready  input  4  per-channel accept.
- s0  output  1  select LSB; current channel = {s1,s0}.
- s1  output  1  select MSB.
- busy  output  1  a word is held (state HOLD).
- drop  output  1  one-cycle pulse when a held word is discarded. Exists only with DEMUX_TIMEOUT_EN.

Behaviour:
- Clocking and reset:
  - Single clock domain, synchronous active-high reset on clk.
  - Reset values: state=IDLE, ptr=0, s0=s1=0, y0..y3=0, y_valid=0, busy=0, drop=0, internal buffer=0, timeout counter=0.
  - Reset asserted mid-HOLD discards the held word. No drop pulse is generated.
- States:
  - IDLE:
    - d_ready = (en_mask != 0). Combinational from state and en_mask.
    - On d_valid && d_ready: capture D into buffer and capture en_mask.
    - sel = first set bit of the captured mask, searching ptr, ptr+1, ... mod 4.
    - Register {s1,s0}=sel. Go to HOLD.
  - HOLD:
    - d_ready=0, busy=1.
    - y_valid[sel]=1 and y<sel>=buffer. Other channels: y=0 and y_valid bit=0. This mirrors demux semantics: non-selected outputs are zero.
    - On y_ready[sel]: next cycle y_valid=0, y<sel>=0, ptr=(sel+1) mod 4, go to IDLE.
    - y_ready on non-selected channels is ignored.
- Latency and throughput:
  - Word accepted at edge N appears on y<sel>/y_valid after edge N, i.e. 1-cycle latency.
  - Maximum throughput is 1 word per 2 cycles. d_ready is low for the whole of HOLD, including the accept cycle.
- Selection rules:
  - en_mask changes during HOLD do not affect the current word; the mask is sampled only at acceptance.
  - With en_mask=0, d_ready=0 and the block stalls in IDLE.
  - Wrap-around: ptr=3 with mask 4'b0011 selects 0; ptr=2 with mask 4'b0100 selects 2.
- Outputs: s0/s1 hold their last value in IDLE and change only on acceptance.

Optional Feature:
- Macro: DEMUX_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to HOLD and increments on each HOLD cycle without y_ready[sel].
  - When the counter reaches TIMEOUT-1 and y_ready[sel]=0, the next edge discards the word: y_valid=0, drop=1 for exactly one cycle, ptr=(sel+1) mod 4, go to IDLE.
  - If y_ready[sel] and expiry coincide, acceptance wins and drop stays 0.
- Undefined: no counter and no drop port. HOLD waits indefinitely.

Test Plan:
- Reset then en_mask=4'b1111, y_ready=4'b1111. Send D=8'hA1,A2,A3,A4,A5 → channels 0,1,2,3,0 in order. Each word appears 1 cycle after its accept. {s1,s0}=0,1,2,3,0. Words spaced 2 cycles apart.
- en_mask=4'b1010, ptr=0. Send D=8'h11,22,33 → channels 1,3,1. y0/y2 and their y_valid bits stay 0 throughout.
- Back-pressure: en_mask=4'b0001, y_ready=0. Send D=8'h5C → y0=8'h5C and y_valid=4'b0001 held 10 cycles, d_ready=0 and busy=1. Raise y_ready[0] → next cycle y_valid=0 and d_ready=1.
- en_mask=0 with d_valid=1 for 5 cycles → d_ready=0, y_valid=0. Then en_mask=4'b0100 → D accepted, routed to channel 2.
- Assert rst during HOLD with y2=8'h77 → next cycle all outputs are at reset values and ptr=0. The next word goes to channel 0.
- DEMUX_TIMEOUT_EN, TIMEOUT=4, y_ready=0. Send D=8'hE0 → y_valid held 4 cycles, then drop=1 for one cycle and ptr advances. Repeat with y_ready[sel] asserted in the 4th HOLD cycle → accepted, drop=0.
